// File: rtl/fifo_pkg.sv
// Shared constants and word type for the synchronous FIFO and its read-side adapters.
package fifo_pkg;
    localparam int fifo_width = 16;
    localparam int fifo_depth = 16;

    typedef logic [fifo_width-1:0] word_t;
endpackage

// File: rtl/fifo_stream_drain_if.sv
// Valid/ready stream carrying FIFO words out of the drain adapter.
interface fifo_stream_drain_if
    import fifo_pkg::*;
#(
    parameter int width = fifo_width
) ();
    logic             m_valid;
    logic [width-1:0] m_data;
    logic             m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order buffer; buf0 is always the head presented to the consumer.
module stream_skid_buf2
    import fifo_pkg::*;
#(
    parameter int width = fifo_width
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [width-1:0] data,
    output logic [1:0]       occ
);
    logic [width-1:0] buf0;
    logic [width-1:0] buf1;
    logic [1:0]       slot;

    // An arriving word lands after any word leaving this cycle has shifted out.
    assign slot = occ - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            occ  <= '0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push && slot == 2'd0) begin
                buf0 <= push_data;
            end else if (pop) begin
                buf0 <= buf1;
            end
            if (push && slot == 2'd1) begin
                buf1 <= push_data;
            end
        end
    end

    assign valid = (occ != 2'd0);
    assign data  = buf0;
endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side adapter: issues FIFO reads, absorbs the 1-cycle read latency and streams words out.
module fifo_stream_drain
    import fifo_pkg::*;
#(
    parameter int width = fifo_width,
    parameter int cnt_w = 16
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic [width-1:0]    fifo_data_out,
    output logic                fifo_read,
    fifo_stream_drain_if.master strm,
    output logic [cnt_w-1:0]    words_sent,
    output logic                busy
);
    logic       inflight;
    logic       pop;
    logic [1:0] occ;
    logic [1:0] fill;

    assign pop  = strm.m_valid && strm.m_ready;
    assign fill = occ + {1'b0, inflight};

    // A read is only issued when its word is guaranteed a slot on arrival.
    assign fifo_read = en && !fifo_empty && (fill < 2'd2 || pop);
    assign busy      = (occ != 2'd0) || inflight;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            inflight   <= 1'b0;
            words_sent <= '0;
        end else begin
            inflight <= fifo_read;
            if (pop) begin
                words_sent <= words_sent + cnt_w'(1);
            end
        end
    end

    stream_skid_buf2 #(
        .width(width)
    ) u_skid (
        .clk      (clk),
        .rst_     (rst_),
        .push     (inflight),
        .push_data(fifo_data_out),
        .pop      (pop),
        .valid    (strm.m_valid),
        .data     (strm.m_data),
        .occ      (occ)
    );
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: FIFO model, count-based reference model and directed scenarios.
module tb_fifo_stream_drain;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b0;
    logic        m_ready = 1'b0;
    logic        push_en = 1'b0;
    word_t       push_data = '0;
    logic        fifo_empty;
    word_t       fifo_data_out;
    logic        fifo_read, fifo_read4;
    logic        busy, busy4;
    logic [15:0] words_sent;
    logic [3:0]  words_sent4;

    fifo_stream_drain_if #(.width(fifo_width)) strm ();
    fifo_stream_drain_if #(.width(fifo_width)) strm4 ();
    assign strm.m_ready  = m_ready;
    assign strm4.m_ready = m_ready;

    fifo_stream_drain #(.width(fifo_width), .cnt_w(16)) dut (
        .clk(clk), .rst_(rst_), .en(en), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_read(fifo_read), .strm(strm),
        .words_sent(words_sent), .busy(busy)
    );

    fifo_stream_drain #(.width(fifo_width), .cnt_w(4)) dut4 (
        .clk(clk), .rst_(rst_), .en(en), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_read(fifo_read4), .strm(strm4),
        .words_sent(words_sent4), .busy(busy4)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail = 0;
    word_t fq[$];
    word_t exp_q[$];
    int    rd_cnt, cap_cnt, hs_cnt;
    logic  prev_hold;
    word_t prev_data;

    // FIFO model plus the reference counts: reads accepted, words landed, words handed off.
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fq.delete();
            exp_q.delete();
            fifo_empty    <= 1'b1;
            fifo_data_out <= '0;
            rd_cnt        <= 0;
            cap_cnt       <= 0;
            hs_cnt        <= 0;
            prev_hold     <= 1'b0;
            prev_data     <= '0;
        end else begin
            if (fifo_read && fq.size() > 0) fifo_data_out <= fq.pop_front();
            if (push_en) begin
                fq.push_back(push_data);
                exp_q.push_back(push_data);
            end
            fifo_empty <= (fq.size() == 0);
            cap_cnt    <= rd_cnt;
            rd_cnt     <= rd_cnt + (fifo_read ? 1 : 0);
            if (strm.m_valid && m_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_hold <= strm.m_valid && !m_ready;
            prev_data <= strm.m_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_) begin
            int   held, pend;
            logic ev, er;
            held = cap_cnt - hs_cnt;
            pend = rd_cnt - hs_cnt;
            ev   = (held > 0);
            er   = en && !fifo_empty && (pend < 2 || (ev && m_ready));
            checkOutput("fifo_read", 32'(fifo_read), 32'(er));
            checkOutput("fifo_read4", 32'(fifo_read4), 32'(er));
            checkOutput("m_valid", 32'(strm.m_valid), 32'(ev));
            checkOutput("m_valid4", 32'(strm4.m_valid), 32'(ev));
            checkOutput("busy", 32'(busy), 32'(pend > 0));
            checkOutput("busy4", 32'(busy4), 32'(pend > 0));
            checkOutput("occ_range", 32'(pend >= 0 && pend <= 2 && held >= 0), 32'd1);
            checkOutput("words_sent", 32'(words_sent), hs_cnt & 32'hFFFF);
            checkOutput("words_sent4", 32'(words_sent4), hs_cnt & 32'hF);
            if (ev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("exp_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    checkOutput("m_data", 32'(strm.m_data), 32'(exp_q[0]));
                    checkOutput("m_data4", 32'(strm4.m_data), 32'(exp_q[0]));
                end
                if (prev_hold) checkOutput("hold", 32'(strm.m_data), 32'(prev_data));
            end
        end
    end

    int    mon_reads, mon_valid, mon_hold, first_v, last_v;
    word_t hold_ref;
    word_t seen[$];

    task automatic clearMon();
        mon_reads = 0; mon_valid = 0; mon_hold = 0; first_v = -1; last_v = -1;
        seen.delete();
    endtask

    // One cycle per call; inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic e, input logic r, input logic p, input word_t d);
        en = e; m_ready = r; push_en = p; push_data = d;
        @(posedge clk); #1;
        push_en = 1'b0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (fifo_read) mon_reads++;
            if (strm.m_valid) begin
                mon_valid++;
                if (first_v < 0) first_v = i;
                last_v = i;
                if (m_ready) seen.push_back(strm.m_data);
                else if (strm.m_data == hold_ref) mon_hold++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic applyReset();
        rst_ = 1'b0; en = 1'b0; m_ready = 1'b0; push_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", 32'(strm.m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(strm.m_data), 32'd0);
        checkOutput("rst_fifo_read", 32'(fifo_read), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_words_sent", 32'(words_sent), 32'd0);
        #1 rst_ = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        word_t t1w[3];
        word_t t2w[5];
        int    pushed, base, edges;
        t1w = '{16'h0011, 16'h0022, 16'h0033};
        t2w = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};

        applyReset();

        // Three preloaded words stream out back to back.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, t1w[i]);
        clearMon();
        en = 1'b1;
        watch(8);
        checkOutput("t1_reads", 32'(mon_reads), 32'd3);
        checkOutput("t1_count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < seen.size() && i < 3; i++) checkOutput("t1_data", 32'(seen[i]), 32'(t1w[i]));
        checkOutput("t1_consecutive", 32'(last_v - first_v), 32'd2);
        checkOutput("t1_words_sent", 32'(words_sent), 32'd3);
        checkOutput("t1_busy", 32'(busy), 32'd0);

        // Stall: two reads fill the buffer, head held until ready returns.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, t2w[i]);
        clearMon();
        hold_ref = t2w[0];
        en = 1'b1;
        watch(12);
        checkOutput("t2_reads", 32'(mon_reads), 32'd2);
        checkOutput("t2_hold_cycles", 32'(mon_hold), 32'd10);
        clearMon();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && seen.size() < 5; i++) watch(1);
        checkOutput("t2_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size() && i < 5; i++) checkOutput("t2_order", 32'(seen[i]), 32'(t2w[i]));

        // Empty FIFO: nothing happens until a word arrives, then 2 edges to the output.
        clearMon();
        watch(10);
        checkOutput("t3_no_read", 32'(mon_reads), 32'd0);
        checkOutput("t3_no_valid", 32'(mon_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hBEEF);
        checkOutput("t3_empty_fell", 32'(fifo_empty), 32'd0);
        edges = 0;
        while (!strm.m_valid && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("t3_latency", 32'(edges), 32'd2);
        checkOutput("t3_data", 32'(strm.m_data), 32'hBEEF);
        watch(3);

        // Random backpressure with 1000 random words.
        pushed = 0;
        base = hs_cnt;
        for (int c = 0; c < 20000 && !(pushed == 1000 && hs_cnt - base == 1000); c++) begin
            if (pushed < 1000 && fq.size() < fifo_depth && $urandom_range(0, 3) != 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, word_t'($urandom));
                pushed++;
            end else begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0);
            end
        end
        checkOutput("t4_delivered", 32'(hs_cnt - base), 32'd1000);
        checkOutput("t4_leftover", 32'(exp_q.size()), 32'd0);

        // en drops with one read in flight: that word still arrives, nothing more is read.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 16'h0A01 + 16'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        en = 1'b0;
        clearMon();
        watch(8);
        checkOutput("t5_reads", 32'(mon_reads), 32'd0);
        checkOutput("t5_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) checkOutput("t5_data", 32'(seen[0]), 32'h0A01);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        clearMon();
        en = 1'b1;
        watch(8);
        checkOutput("t5_rest", 32'(seen.size()), 32'd2);

        // Counter wrap on the 4-bit instance, then an asynchronous reset mid-stream.
        applyReset();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b1, 16'(i + 1));
        watch(6);
        checkOutput("t6_words_sent", 32'(words_sent), 32'd17);
        checkOutput("t6_wrap4", 32'(words_sent4), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h0C00 + 16'(i));
        watch(3);
        checkOutput("t6_pre_valid", 32'(strm.m_valid), 32'd1);
        #2 rst_ = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(strm.m_valid), 32'd0);
        checkOutput("t6_async_words", 32'(words_sent), 32'd0);
        checkOutput("t6_async_words4", 32'(words_sent4), 32'd0);
        checkOutput("t6_async_read", 32'(fifo_read), 32'd0);
        checkOutput("t6_async_busy", 32'(busy), 32'd0);
        #3 rst_ = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
